icb_imem_arbiter: RTL and testbench

ICB_IMEM_ARBITER -- requirements
Module: icb_imem_arbiter

---
 rtl/icb_imem_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_icb_imem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_imem_arbiter.sv
//------------------------------------------------------------------------------
// icb_imem_arbiter
//
// Purpose
//   Shares one ICB-SRAM controller port between two requesters:
//   s0 = instruction bus and s1 = data bus. The granted command is forwarded
//   combinationally to m_icb_cmd_*. Every accepted command pushes the
//   requester ID into a small routing FIFO. The FIFO head steers each response
//   back to its owner, so each requester gets its responses in command order.
//   A response that arrives with nothing outstanding is dropped and flagged on
//   rsp_orphan, one cycle later.
//
// Build option
//   ICB_IMEM_ARB_ROUND_ROBIN_EN
//     defined   : round robin when both requesters are valid
//     undefined : fixed priority to s1 (data bus); no round-robin pointer
//
// Parameters
//   outstanding_max  : depth of the routing FIFO (legal 1..8)
//   simulation_delay : kept for interface compatibility; registers here
//                      update with zero delay
//
// Ports
//   clk, rst                     : clock, asynchronous active-high reset
//   s0_icb_cmd_* / s0_icb_rsp_*  : requester 0 (instruction bus) ICB slave side
//   s1_icb_cmd_* / s1_icb_rsp_*  : requester 1 (data bus) ICB slave side
//   m_icb_cmd_*  / m_icb_rsp_*   : ICB master side toward the SRAM controller
//   rsp_orphan                   : one-cycle pulse after an unexpected response
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module icb_imem_arbiter #(
  parameter int unsigned outstanding_max  = 4,
  parameter int unsigned simulation_delay = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] s0_icb_cmd_addr,
  input  logic        s0_icb_cmd_read,
  input  logic [31:0] s0_icb_cmd_wdata,
  input  logic [3:0]  s0_icb_cmd_wmask,
  input  logic        s0_icb_cmd_valid,
  output logic        s0_icb_cmd_ready,
  output logic [31:0] s0_icb_rsp_rdata,
  output logic        s0_icb_rsp_err,
  output logic        s0_icb_rsp_valid,
  input  logic        s0_icb_rsp_ready,

  input  logic [31:0] s1_icb_cmd_addr,
  input  logic        s1_icb_cmd_read,
  input  logic [31:0] s1_icb_cmd_wdata,
  input  logic [3:0]  s1_icb_cmd_wmask,
  input  logic        s1_icb_cmd_valid,
  output logic        s1_icb_cmd_ready,
  output logic [31:0] s1_icb_rsp_rdata,
  output logic        s1_icb_rsp_err,
  output logic        s1_icb_rsp_valid,
  input  logic        s1_icb_rsp_ready,

  output logic [31:0] m_icb_cmd_addr,
  output logic        m_icb_cmd_read,
  output logic [31:0] m_icb_cmd_wdata,
  output logic [3:0]  m_icb_cmd_wmask,
  output logic        m_icb_cmd_valid,
  input  logic        m_icb_cmd_ready,
  input  logic [31:0] m_icb_rsp_rdata,
  input  logic        m_icb_rsp_err,
  input  logic        m_icb_rsp_valid,
  output logic        m_icb_rsp_ready,

  output logic        rsp_orphan
);

  localparam int unsigned CNT_W = $clog2(outstanding_max + 1);
  localparam int unsigned PTR_W = (outstanding_max > 1) ? $clog2(outstanding_max) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(outstanding_max);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(outstanding_max - 1);

  // simulation_delay has no effect on this zero-delay implementation.
  if (simulation_delay != 0) begin : g_sim_delay_not_modelled
  end

  typedef enum logic {
    REQ_S0 = 1'b0,
    REQ_S1 = 1'b1
  } req_id_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             lock_q,   lock_d;
  req_id_e          lock_id_q, lock_id_d;
  logic             orphan_q, orphan_d;
  req_id_e          id_mem_q [outstanding_max];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic    fifo_full;
  logic    fifo_empty;
  req_id_e head_id;
  req_id_e prio_id;     // winner when both requesters are valid and unlocked
  req_id_e gnt_id;
  logic    gnt_valid;
  logic    cmd_hs;      // command handshake -> push
  logic    rsp_pop;     // response handshake with a live entry -> pop

  // Flags come from the registered count only. A pop in this cycle therefore
  // cannot make room for a push in the same cycle.
  assign fifo_full  = (count_q == CNT_MAX);
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Priority source
  // ---------------------------------------------------------------------------
`ifdef ICB_IMEM_ARB_ROUND_ROBIN_EN
  req_id_e last_q, last_d;

  // The pointer moves only on an accepted command. Stalls or idle cycles
  // do not move it.
  assign last_d  = cmd_hs ? gnt_id : last_q;
  assign prio_id = (last_q == REQ_S0) ? REQ_S1 : REQ_S0;

  // Reset value REQ_S1 means requester 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_S1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign prio_id = REQ_S1;
`endif

  // ---------------------------------------------------------------------------
  // Grant selection and command forwarding
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_id = REQ_S0;
    if (lock_q) begin
      // A stalled command keeps the bus until it is accepted.
      gnt_id = lock_id_q;
    end else if (s0_icb_cmd_valid && s1_icb_cmd_valid) begin
      gnt_id = prio_id;
    end else if (s1_icb_cmd_valid) begin
      gnt_id = REQ_S1;
    end
  end

  assign gnt_valid = (gnt_id == REQ_S1) ? s1_icb_cmd_valid : s0_icb_cmd_valid;

  assign m_icb_cmd_addr  = (gnt_id == REQ_S1) ? s1_icb_cmd_addr  : s0_icb_cmd_addr;
  assign m_icb_cmd_read  = (gnt_id == REQ_S1) ? s1_icb_cmd_read  : s0_icb_cmd_read;
  assign m_icb_cmd_wdata = (gnt_id == REQ_S1) ? s1_icb_cmd_wdata : s0_icb_cmd_wdata;
  assign m_icb_cmd_wmask = (gnt_id == REQ_S1) ? s1_icb_cmd_wmask : s0_icb_cmd_wmask;

  // A full routing FIFO hides the command from the controller. A command that
  // is accepted there would have no slot to record its owner.
  assign m_icb_cmd_valid  = !rst && !fifo_full && gnt_valid;
  assign s0_icb_cmd_ready = !rst && !fifo_full && m_icb_cmd_ready && (gnt_id == REQ_S0);
  assign s1_icb_cmd_ready = !rst && !fifo_full && m_icb_cmd_ready && (gnt_id == REQ_S1);

  assign cmd_hs = m_icb_cmd_valid && m_icb_cmd_ready;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    m_icb_rsp_ready  = 1'b1;   // nothing owed: accept and drop
    s0_icb_rsp_valid = 1'b0;
    s0_icb_rsp_rdata = '0;
    s0_icb_rsp_err   = 1'b0;
    s1_icb_rsp_valid = 1'b0;
    s1_icb_rsp_rdata = '0;
    s1_icb_rsp_err   = 1'b0;
    if (!rst && !fifo_empty) begin
      if (head_id == REQ_S1) begin
        s1_icb_rsp_valid = m_icb_rsp_valid;
        s1_icb_rsp_rdata = m_icb_rsp_rdata;
        s1_icb_rsp_err   = m_icb_rsp_err;
        m_icb_rsp_ready  = s1_icb_rsp_ready;
      end else begin
        s0_icb_rsp_valid = m_icb_rsp_valid;
        s0_icb_rsp_rdata = m_icb_rsp_rdata;
        s0_icb_rsp_err   = m_icb_rsp_err;
        m_icb_rsp_ready  = s0_icb_rsp_ready;
      end
    end
  end

  assign rsp_pop = !fifo_empty && m_icb_rsp_valid && m_icb_rsp_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lock_d    = m_icb_cmd_valid && !m_icb_cmd_ready;
    lock_id_d = gnt_id;
    orphan_d  = fifo_empty && m_icb_rsp_valid;

    if (cmd_hs) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rsp_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({cmd_hs, rsp_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;   // idle, or push and pop together
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= REQ_S0;
      orphan_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      orphan_q  <= orphan_d;
    end
  end

  // NOTE: the routing storage is not reset. An entry is read only while
  // count_q says it holds a live ID, so clearing the count is enough to drop
  // outstanding traffic.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      id_mem_q[wr_ptr_q] <= gnt_id;
    end
  end

  assign rsp_orphan = orphan_q;

endmodule

// File: tb/tb_icb_imem_arbiter.sv
`timescale 1ns/1ps

module tb_icb_imem_arbiter;

  localparam int OM = 4;
`ifdef ICB_IMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_icb_cmd_addr, s1_icb_cmd_addr, m_icb_cmd_addr;
  logic        s0_icb_cmd_read, s1_icb_cmd_read, m_icb_cmd_read;
  logic [31:0] s0_icb_cmd_wdata, s1_icb_cmd_wdata, m_icb_cmd_wdata;
  logic [3:0]  s0_icb_cmd_wmask, s1_icb_cmd_wmask, m_icb_cmd_wmask;
  logic        s0_icb_cmd_valid, s1_icb_cmd_valid, m_icb_cmd_valid;
  logic        s0_icb_cmd_ready, s1_icb_cmd_ready, m_icb_cmd_ready;
  logic [31:0] s0_icb_rsp_rdata, s1_icb_rsp_rdata, m_icb_rsp_rdata;
  logic        s0_icb_rsp_err, s1_icb_rsp_err, m_icb_rsp_err;
  logic        s0_icb_rsp_valid, s1_icb_rsp_valid, m_icb_rsp_valid;
  logic        s0_icb_rsp_ready, s1_icb_rsp_ready, m_icb_rsp_ready;
  logic        rsp_orphan;

  icb_imem_arbiter #(.outstanding_max(OM), .simulation_delay(1)) dut (
    .clk(clk), .rst(rst),
    .s0_icb_cmd_addr(s0_icb_cmd_addr), .s0_icb_cmd_read(s0_icb_cmd_read),
    .s0_icb_cmd_wdata(s0_icb_cmd_wdata), .s0_icb_cmd_wmask(s0_icb_cmd_wmask),
    .s0_icb_cmd_valid(s0_icb_cmd_valid), .s0_icb_cmd_ready(s0_icb_cmd_ready),
    .s0_icb_rsp_rdata(s0_icb_rsp_rdata), .s0_icb_rsp_err(s0_icb_rsp_err),
    .s0_icb_rsp_valid(s0_icb_rsp_valid), .s0_icb_rsp_ready(s0_icb_rsp_ready),
    .s1_icb_cmd_addr(s1_icb_cmd_addr), .s1_icb_cmd_read(s1_icb_cmd_read),
    .s1_icb_cmd_wdata(s1_icb_cmd_wdata), .s1_icb_cmd_wmask(s1_icb_cmd_wmask),
    .s1_icb_cmd_valid(s1_icb_cmd_valid), .s1_icb_cmd_ready(s1_icb_cmd_ready),
    .s1_icb_rsp_rdata(s1_icb_rsp_rdata), .s1_icb_rsp_err(s1_icb_rsp_err),
    .s1_icb_rsp_valid(s1_icb_rsp_valid), .s1_icb_rsp_ready(s1_icb_rsp_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .rsp_orphan(rsp_orphan)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It tracks the list of owners still owed a response, an
  // optional stalled owner and the last winner. All outputs are derived from
  // these every cycle.
  // ---------------------------------------------------------------------------
  int   route_q[$];
  bit   m_lock_v   = 1'b0;
  int   m_lock_id  = 0;
  int   m_last     = 1;
  bit   m_orphan   = 1'b0;
  int   dut_gnt_log[$];     // owner of each observed DUT command handshake

  int   m_g, m_head;
  bit   m_full, m_empty, m_mv, m_mrr, m_pop, m_hs;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_s0_cmd_ready", s0_icb_cmd_ready, 0);
      check("rst_s1_cmd_ready", s1_icb_cmd_ready, 0);
      check("rst_m_cmd_valid",  m_icb_cmd_valid,  0);
      check("rst_s0_rsp_valid", s0_icb_rsp_valid, 0);
      check("rst_s1_rsp_valid", s1_icb_rsp_valid, 0);
      check("rst_m_rsp_ready",  m_icb_rsp_ready,  1);
      check("rst_orphan",       rsp_orphan,       0);
      route_q.delete();
      m_lock_v = 1'b0;
      m_last   = 1;
      m_orphan = 1'b0;
    end else begin
      m_full  = (route_q.size() == OM);
      m_empty = (route_q.size() == 0);
      if (m_lock_v)                                  m_g = m_lock_id;
      else if (s0_icb_cmd_valid && s1_icb_cmd_valid) m_g = RR ? (1 - m_last) : 1;
      else if (s1_icb_cmd_valid)                     m_g = 1;
      else                                           m_g = 0;
      m_mv = !m_full && ((m_g == 1) ? s1_icb_cmd_valid : s0_icb_cmd_valid);

      check("m_cmd_valid",  m_icb_cmd_valid,  m_mv);
      check("s0_cmd_ready", s0_icb_cmd_ready, !m_full && m_g == 0 && m_icb_cmd_ready);
      check("s1_cmd_ready", s1_icb_cmd_ready, !m_full && m_g == 1 && m_icb_cmd_ready);
      if (m_mv) begin
        check("m_cmd_addr",  m_icb_cmd_addr,  (m_g == 1) ? s1_icb_cmd_addr  : s0_icb_cmd_addr);
        check("m_cmd_read",  m_icb_cmd_read,  (m_g == 1) ? s1_icb_cmd_read  : s0_icb_cmd_read);
        check("m_cmd_wdata", m_icb_cmd_wdata, (m_g == 1) ? s1_icb_cmd_wdata : s0_icb_cmd_wdata);
        check("m_cmd_wmask", m_icb_cmd_wmask, (m_g == 1) ? s1_icb_cmd_wmask : s0_icb_cmd_wmask);
      end

      m_head = m_empty ? -1 : route_q[0];
      m_mrr  = m_empty ? 1'b1 : ((m_head == 1) ? s1_icb_rsp_ready : s0_icb_rsp_ready);
      check("m_rsp_ready",  m_icb_rsp_ready,  m_mrr);
      check("s0_rsp_valid", s0_icb_rsp_valid, (m_head == 0) && m_icb_rsp_valid);
      check("s1_rsp_valid", s1_icb_rsp_valid, (m_head == 1) && m_icb_rsp_valid);
      check("s0_rsp_rdata", s0_icb_rsp_rdata, (m_head == 0) ? m_icb_rsp_rdata : 32'h0);
      check("s1_rsp_rdata", s1_icb_rsp_rdata, (m_head == 1) ? m_icb_rsp_rdata : 32'h0);
      check("s0_rsp_err",   s0_icb_rsp_err,   (m_head == 0) && m_icb_rsp_err);
      check("s1_rsp_err",   s1_icb_rsp_err,   (m_head == 1) && m_icb_rsp_err);
      check("rsp_orphan",   rsp_orphan,       m_orphan);

      if (s0_icb_cmd_valid && s0_icb_cmd_ready) dut_gnt_log.push_back(0);
      if (s1_icb_cmd_valid && s1_icb_cmd_ready) dut_gnt_log.push_back(1);

      m_pop = !m_empty && m_icb_rsp_valid && m_mrr;
      m_hs  = m_mv && m_icb_cmd_ready;
      if (m_pop) void'(route_q.pop_front());
      if (m_hs) begin
        route_q.push_back(m_g);
        m_last = m_g;
      end
      m_lock_v  = m_mv && !m_icb_cmd_ready;
      m_lock_id = m_g;
      m_orphan  = m_empty && m_icb_rsp_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_icb_cmd_valid = 0; s0_icb_cmd_addr = 0; s0_icb_cmd_read = 0;
    s0_icb_cmd_wdata = 0; s0_icb_cmd_wmask = 0; s0_icb_rsp_ready = 1;
    s1_icb_cmd_valid = 0; s1_icb_cmd_addr = 0; s1_icb_cmd_read = 0;
    s1_icb_cmd_wdata = 0; s1_icb_cmd_wmask = 0; s1_icb_rsp_ready = 1;
    m_icb_cmd_ready = 1; m_icb_rsp_valid = 0; m_icb_rsp_rdata = 0; m_icb_rsp_err = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    // Reset state with both requesters knocking.
    step();
    s0_icb_cmd_valid = 1; s1_icb_cmd_valid = 1;
    #2;
    check("lit_rst_s0_cmd_ready", s0_icb_cmd_ready, 0);
    check("lit_rst_m_cmd_valid",  m_icb_cmd_valid,  0);
    check("lit_rst_m_rsp_ready",  m_icb_rsp_ready,  1);
    step(); idle();
    step(); rst = 1'b0;

    // --- s0 single read, answered one cycle later -------------------------
    step();
    s0_icb_cmd_valid = 1; s0_icb_cmd_read = 1; s0_icb_cmd_addr = 32'h0000_0010;
    #2;
    check("s1_cmd_ready_hs", s0_icb_cmd_ready, 1);
    check("s1_cmd_addr",     m_icb_cmd_addr,   32'h0000_0010);
    step(); idle();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'h1234_5678;
    #2;
    check("s1_rsp_valid",    s0_icb_rsp_valid, 1);
    check("s1_rsp_rdata",    s0_icb_rsp_rdata, 32'h1234_5678);
    check("s1_rsp_err",      s0_icb_rsp_err,   0);
    check("s1_s1_rsp_valid", s1_icb_rsp_valid, 0);
    step(); idle();
    #2;
    check("s1_after_s0_valid", s0_icb_rsp_valid, 0);

    // --- contention: 6 back-to-back handshakes after a fresh reset ---------
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    dut_gnt_log.delete();
    step();
    s0_icb_cmd_valid = 1; s0_icb_cmd_read = 1; s0_icb_cmd_addr = 32'h100;
    s1_icb_cmd_valid = 1; s1_icb_cmd_read = 0; s1_icb_cmd_addr = 32'h200;
    s1_icb_cmd_wdata = 32'h55; s1_icb_cmd_wmask = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      step();
      m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hA000_0000 + i;
    end
    step();
    s0_icb_cmd_valid = 0; s1_icb_cmd_valid = 0;
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hA000_0006;
    step(); idle();
    check("s2_hs_count", dut_gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < dut_gnt_log.size(); i++) begin
      check($sformatf("s2_grant_%0d", i), dut_gnt_log[i], RR ? (i % 2) : 1);
    end

    // --- s1 five writes with no responses: fifth waits for a free slot -----
    dut_gnt_log.delete();
    for (int k = 0; k < 4; k++) begin
      step();
      s1_icb_cmd_valid = 1; s1_icb_cmd_read = 0; s1_icb_cmd_addr = 32'h40 + 4 * k;
      s1_icb_cmd_wdata = 32'hB0 + k; s1_icb_cmd_wmask = 4'hF;
      #2;
      check($sformatf("s3_accept_%0d", k), s1_icb_cmd_ready, 1);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      s1_icb_cmd_addr = 32'h50; s1_icb_cmd_wdata = 32'hB4;
      #2;
      check("s3_full_ready", s1_icb_cmd_ready, 0);
      check("s3_full_valid", m_icb_cmd_valid,  0);
    end
    step();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hC1;
    #2;
    check("s3_pop_cycle_ready", s1_icb_cmd_ready, 0);
    check("s3_pop_rsp_valid",   s1_icb_rsp_valid, 1);
    step();
    m_icb_rsp_valid = 0;
    #2;
    check("s3_after_pop_ready", s1_icb_cmd_ready, 1);
    check("s3_accepted_4",      dut_gnt_log.size(), 4);
    for (int k = 2; k <= 5; k++) begin
      step();
      s1_icb_cmd_valid = 0;
      m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hC0 + k;
    end
    step(); idle();
    check("s3_accepted_5", dut_gnt_log.size(), 5);

    // --- locked grant: s0 stalled, s1 arrives during the stall -------------
    step();
    s0_icb_cmd_valid = 1; s0_icb_cmd_read = 1; s0_icb_cmd_addr = 32'h300;
    m_icb_cmd_ready = 0;
    #2;
    check("s4_c0_addr", m_icb_cmd_addr, 32'h300);
    step();
    s1_icb_cmd_valid = 1; s1_icb_cmd_read = 0; s1_icb_cmd_addr = 32'h400;
    s1_icb_cmd_wdata = 32'h77; s1_icb_cmd_wmask = 4'h3;
    #2;
    check("s4_c1_addr", m_icb_cmd_addr, 32'h300);
    check("s4_c1_read", m_icb_cmd_read, 1);
    step();
    #2;
    check("s4_c2_addr", m_icb_cmd_addr, 32'h300);
    step();
    m_icb_cmd_ready = 1;
    #2;
    check("s4_c3_addr",      m_icb_cmd_addr,   32'h300);
    check("s4_c3_s0_ready",  s0_icb_cmd_ready, 1);
    check("s4_c3_s1_ready",  s1_icb_cmd_ready, 0);
    step();
    s0_icb_cmd_valid = 0;
    #2;
    check("s4_c4_addr", m_icb_cmd_addr, 32'h400);
    step();
    s1_icb_cmd_valid = 0;
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hD0; s0_icb_rsp_ready = 0;
    #2;
    check("s4_bp_m_rsp_ready", m_icb_rsp_ready, 0);
    check("s4_bp_s0_valid",    s0_icb_rsp_valid, 1);
    step();
    s0_icb_rsp_ready = 1;
    step();
    m_icb_rsp_rdata = 32'hD1; m_icb_rsp_err = 1;
    #2;
    check("s4_s1_rsp_valid", s1_icb_rsp_valid, 1);
    check("s4_s1_rsp_rdata", s1_icb_rsp_rdata, 32'hD1);
    check("s4_s1_rsp_err",   s1_icb_rsp_err,   1);
    check("s4_s0_rsp_rdata", s0_icb_rsp_rdata, 0);
    step(); idle();

    // --- orphan response ----------------------------------------------------
    step();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hDEAD;
    #2;
    check("s5_s0_valid",   s0_icb_rsp_valid, 0);
    check("s5_s1_valid",   s1_icb_rsp_valid, 0);
    check("s5_m_rsp_rdy",  m_icb_rsp_ready,  1);
    step();
    m_icb_rsp_valid = 0;
    #2;
    check("s5_orphan_hi", rsp_orphan, 1);
    step();
    #2;
    check("s5_orphan_lo", rsp_orphan, 0);

    // --- reset with three commands outstanding ------------------------------
    for (int k = 0; k < 3; k++) begin
      step();
      s0_icb_cmd_valid = 1; s0_icb_cmd_read = 1; s0_icb_cmd_addr = 32'h500 + 4 * k;
    end
    step();
    s0_icb_cmd_valid = 0;
    #1;
    check("s6_count_before", dut.count_q, 3);
    rst = 1'b1;
    #1;
    check("s6_count_on_rst", dut.count_q, 0);
    check("s6_rst_rsp_rdy",  m_icb_rsp_ready, 1);
    step(); rst = 1'b0;
    step();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hEE;
    #2;
    check("s6_late_s0_valid", s0_icb_rsp_valid, 0);
    step();
    m_icb_rsp_valid = 0;
    #2;
    check("s6_late_orphan", rsp_orphan, 1);
    step(); idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
